// File: rtl/aqalu_pkg.sv
// -----------------------------------------------------------------------------
// aqalu_pkg
//   Shared definitions for the AQALU command driver: opcode constants, the
//   driver FSM state encoding and the packed command record that travels
//   through the command FIFO.
// -----------------------------------------------------------------------------
package aqalu_pkg;

   localparam logic [3:0] OP_IDLE   = 4'b0000;
   localparam logic [3:0] OP_RUNSUM = 4'b1111;   // stateful running-sum opcode

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] a;
      logic [1:0] b;
   } cmd_t;

   // Builds a command record from its fields.
   function automatic cmd_t make_cmd(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b);
      cmd_t c;
      c.opcode = op;
      c.a      = a;
      c.b      = b;
      return c;
   endfunction

endpackage

// File: rtl/aqalu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// aqalu_cmd_fifo
//   Synchronous FIFO of cmd_t records, DEPTH entries (power of 2, >= 2).
//   Full/empty come straight from the registered occupancy count, so a push
//   is refused while full even if a pop happens in the same cycle.
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-low
//   i_push   in   push request (ignored while full)
//   i_data   in   command written on push
//   i_pop    in   pop request (ignored while empty)
//   o_data   out  head-of-queue command (valid while !o_empty)
//   o_full   out  occupancy == DEPTH
//   o_empty  out  occupancy == 0
// -----------------------------------------------------------------------------
module aqalu_cmd_fifo
   import aqalu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic i_push,
   input  cmd_t i_data,
   input  logic i_pop,
   output cmd_t o_data,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   cmd_t          r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == {CW{1'b0}});
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/aqalu_cmd_driver.sv
// -----------------------------------------------------------------------------
// aqalu_cmd_driver
//   Feeds the AQALU from a valid/ready command stream: queues {opcode,A,B},
//   applies one command at a time to the ALU inputs, waits ALU_LAT clocks,
//   captures the ALU Output and returns it on a valid/ready response port.
//   Also owns the seconds tick/counter used to timestamp ALU activity.
//   Optional feature macro: AQALU_TIMESTAMP_EN adds rsp_seconds, the seconds
//   value sampled in the rsp_data capture cycle.
// Ports
//   clock, reset (sync, active-low)
//   cmd_valid/cmd_ready/cmd_opcode/cmd_a/cmd_b   command input
//   alu_A/alu_B/alu_Opcode (out), alu_Output (in) AQALU interface
//   rsp_valid/rsp_ready/rsp_data/rsp_opcode      response output
//   sec_tick, seconds                            1-second tick and counter
//   rsp_seconds                                  (AQALU_TIMESTAMP_EN only)
// -----------------------------------------------------------------------------
module aqalu_cmd_driver
   import aqalu_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int ALU_LAT  = 1,
   parameter int TICK_DIV = 10_000_000,
   parameter int OUT_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [1:0]       cmd_a,
   input  logic [1:0]       cmd_b,
   output logic [1:0]       alu_A,
   output logic [1:0]       alu_B,
   output logic [3:0]       alu_Opcode,
   input  logic [OUT_W-1:0] alu_Output,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [OUT_W-1:0] rsp_data,
   output logic [3:0]       rsp_opcode,
   output logic             sec_tick,
   output logic [7:0]       seconds
`ifdef AQALU_TIMESTAMP_EN
   ,output logic [7:0]      rsp_seconds
`endif
);

   localparam int LCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [LCW-1:0] LAT_LAST = LCW'(ALU_LAT - 1);
   localparam logic [TW-1:0]  TICK_MAX = TW'(TICK_DIV - 1);

   state_t           r_state;
   state_t           w_next_state;
   cmd_t             w_fifo_rd;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_pop;
   logic             w_issue;
   logic             w_capture;
   logic             w_rsp_done;
   logic             w_lat_last;
   cmd_t             r_cmd;
   logic [LCW-1:0]   r_lat_cnt;
   logic [1:0]       r_alu_a;
   logic [1:0]       r_alu_b;
   logic [3:0]       r_alu_opcode;
   logic             r_rsp_valid;
   logic [OUT_W-1:0] r_rsp_data;
   logic [3:0]       r_rsp_opcode;
   logic [TW-1:0]    r_tick_cnt;
   logic             r_sec_tick;
   logic [7:0]       r_seconds;
`ifdef AQALU_TIMESTAMP_EN
   logic [7:0]       r_rsp_seconds;
   assign rsp_seconds = r_rsp_seconds;
`endif

   aqalu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (cmd_valid),
      .i_data  (make_cmd(cmd_opcode, cmd_a, cmd_b)),
      .i_pop   (w_pop),
      .o_data  (w_fifo_rd),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign cmd_ready  = !w_fifo_full;
   assign alu_A      = r_alu_a;
   assign alu_B      = r_alu_b;
   assign alu_Opcode = r_alu_opcode;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_opcode = r_rsp_opcode;
   assign sec_tick   = r_sec_tick;
   assign seconds    = r_seconds;
   assign w_lat_last = (r_lat_cnt == LAT_LAST);

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // FSM next state and per-state control strobes.
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_issue      = 1'b0;
      w_capture    = 1'b0;
      w_rsp_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_pop        = 1'b1;
               w_next_state = ISSUE;
            end else begin
               w_next_state = IDLE;
            end
         end
         ISSUE: begin
            w_issue      = 1'b1;
            w_next_state = WAIT;
         end
         WAIT: begin
            if (w_lat_last) begin
               w_capture    = 1'b1;
               w_next_state = RESP;
            end else begin
               w_next_state = WAIT;
            end
         end
         RESP: begin
            // rsp_valid is always high in RESP, so rsp_ready alone completes it.
            if (rsp_ready) begin
               w_rsp_done   = 1'b1;
               w_next_state = IDLE;
            end else begin
               w_next_state = RESP;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Command datapath: popped-command holding register, ALU drive, latency
   // counter and response capture. ALU inputs keep the last command between
   // issues so stateful opcodes continue to evolve.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cmd         <= make_cmd(OP_IDLE, 2'd0, 2'd0);
         r_alu_a       <= 2'd0;
         r_alu_b       <= 2'd0;
         r_alu_opcode  <= OP_IDLE;
         r_lat_cnt     <= {LCW{1'b0}};
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= {OUT_W{1'b0}};
         r_rsp_opcode  <= 4'd0;
`ifdef AQALU_TIMESTAMP_EN
         r_rsp_seconds <= 8'd0;
`endif
      end else begin
         if (w_pop) r_cmd <= w_fifo_rd;
         if (w_issue) begin
            r_alu_a      <= r_cmd.a;
            r_alu_b      <= r_cmd.b;
            r_alu_opcode <= r_cmd.opcode;
            r_lat_cnt    <= {LCW{1'b0}};
         end else if ((r_state == WAIT) && !w_lat_last) begin
            r_lat_cnt <= r_lat_cnt + LCW'(1);
         end
         if (w_capture) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= alu_Output;
            r_rsp_opcode  <= r_alu_opcode;
`ifdef AQALU_TIMESTAMP_EN
            r_rsp_seconds <= r_seconds;
`endif
         end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   // Free-running seconds timebase, independent of the command FSM.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_tick_cnt <= {TW{1'b0}};
         r_sec_tick <= 1'b0;
         r_seconds  <= 8'd0;
      end else if (r_tick_cnt == TICK_MAX) begin
         r_tick_cnt <= {TW{1'b0}};
         r_sec_tick <= 1'b1;
         r_seconds  <= r_seconds + 8'd1;
      end else begin
         r_tick_cnt <= r_tick_cnt + TW'(1);
         r_sec_tick <= 1'b0;
      end
   end

endmodule
